// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: FSM encoding, default widths, counter helper.
// Imported by fetch_queue and instr_fetch.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int ADDR_W_DEF  = 8;
  localparam int INSTR_W_DEF = 16;
  localparam int CNT_W       = 16;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {addr, instr}; push/pop/flush, count/full/empty.
// Ports: clk, rst, push, push_addr, push_data, pop, flush, head_*, count, full, empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = ADDR_W_DEF,
  parameter int DW    = INSTR_W_DEF,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [CW-1:0] wr_q;
  logic [CW-1:0] rd_q;
  logic          pop_ok;
  logic          push_ok;

  assign count = wr_q - rd_q;
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  assign pop_ok  = pop && !empty;
  // Full queue may still accept when the head leaves this cycle.
  assign push_ok = push && (!full || pop_ok);

  assign head_addr = addr_mem[rd_q[PW-1:0]];
  assign head_data = data_mem[rd_q[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else if (flush) begin
      rd_q <= wr_q;
    end else begin
      if (push_ok) begin
        addr_mem[wr_q[PW-1:0]] <= push_addr;
        data_mem[wr_q[PW-1:0]] <= push_data;
        wr_q <= wr_q + CW'(1);
      end
      if (pop_ok) begin
        rd_q <= rd_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, 1-cycle ROM requests, prefetch queue, redirect flush.
// Ports: clk_in, rst_in, en_in, mem_req/addr_out, mem_data_in, instr/pc/valid_out,
// ready_in, redirect_in, redirect_addr_in; FETCH_PERF_CNT_EN adds stall/flush counters.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int DEPTH   = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               en_in,
  output logic               mem_req_out,
  output logic [ADDR_W-1:0]  mem_addr_out,
  input  logic [INSTR_W-1:0] mem_data_in,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               valid_out,
  input  logic               ready_in,
  input  logic               redirect_in,
  input  logic [ADDR_W-1:0]  redirect_addr_in
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        stall_cnt_out,
  output logic [15:0]        flush_cnt_out
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = CW + 1;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] pc_q;
  logic              inflight_q;
  logic [ADDR_W-1:0] inflight_addr_q;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              pop;
  logic              push;
  logic              req;
  logic [OW-1:0]     occ;
  logic [OW-1:0]     lim;

  assign valid_out    = !empty;
  assign pop          = valid_out && ready_in;
  assign mem_req_out  = req;
  assign mem_addr_out = pc_q;

  // A response is dropped if a redirect lands with it or it was
  // requested in the redirect cycle (it then arrives during FLUSH).
  assign push = inflight_q && !redirect_in && (state_q != FLUSH);

  // Credit the slot freed by this cycle's pop so a 1/cycle stream
  // needs only DEPTH entries.
  always_comb begin
    occ = {1'b0, count} + {{CW{1'b0}}, inflight_q};
    lim = OW'(DEPTH) + {{CW{1'b0}}, pop};
    req = (state_q == RUN) && en_in && (!full || pop) && (occ < lim);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en_in && !redirect_in) state_d = RUN;
      RUN:     if (redirect_in) state_d = FLUSH;
               else if (!en_in) state_d = IDLE;
      FLUSH:   state_d = redirect_in ? FLUSH : RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q         <= IDLE;
      pc_q            <= RESET_PC;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= req;
      if (req) inflight_addr_q <= pc_q;
      if (redirect_in) pc_q <= redirect_addr_in;
      else if (req) pc_q <= pc_q + ADDR_W'(1);
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .AW    (ADDR_W),
    .DW    (INSTR_W)
  ) u_queue (
    .clk       (clk_in),
    .rst       (rst_in),
    .push      (push),
    .push_addr (inflight_addr_q),
    .push_data (mem_data_in),
    .pop       (pop),
    .flush     (redirect_in),
    .head_addr (pc_out),
    .head_data (instr_out),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (valid_out && !ready_in) stall_q <= sat_inc(stall_q);
      if (redirect_in) flush_q <= sat_inc(flush_q);
    end
  end

  assign stall_cnt_out = stall_q;
  assign flush_cnt_out = flush_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: table-driven stream plus reset,
// wrap, double-redirect and (FETCH_PERF_CNT_EN) counter sequences.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        ready = 1'b0;
  logic        redir = 1'b0;
  logic [7:0]  raddr = 8'h00;
  logic        req;
  logic [7:0]  addr;
  logic [15:0] rom_q;
  logic [15:0] instr;
  logic [7:0]  pc;
  logic        valid;

  logic        en_fe = 1'b0;
  logic        req_fe;
  logic [7:0]  addr_fe;
  logic [15:0] rom_fe;
  logic [15:0] instr_fe;
  logic [7:0]  pc_fe;
  logic        valid_fe;

  int checks = 0;
  int errors = 0;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic [15:0] stall_fe;
  logic [15:0] flush_fe;
`endif

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (req) rom_q <= 16'hA000 + {8'h00, addr};
    if (req_fe) rom_fe <= 16'hA000 + {8'h00, addr_fe};
  end

  instr_fetch #(.RESET_PC(8'h00)) dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .en_in            (en),
    .mem_req_out      (req),
    .mem_addr_out     (addr),
    .mem_data_in      (rom_q),
    .instr_out        (instr),
    .pc_out           (pc),
    .valid_out        (valid),
    .ready_in         (ready),
    .redirect_in      (redir),
    .redirect_addr_in (raddr)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cnt_out    (stall_cnt),
    .flush_cnt_out    (flush_cnt)
`endif
  );

  instr_fetch #(.RESET_PC(8'hFE)) dut_fe (
    .clk_in           (clk),
    .rst_in           (rst),
    .en_in            (en_fe),
    .mem_req_out      (req_fe),
    .mem_addr_out     (addr_fe),
    .mem_data_in      (rom_fe),
    .instr_out        (instr_fe),
    .pc_out           (pc_fe),
    .valid_out        (valid_fe),
    .ready_in         (1'b1),
    .redirect_in      (1'b0),
    .redirect_addr_in (8'h00)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cnt_out    (stall_fe),
    .flush_cnt_out    (flush_fe)
`endif
  );

  typedef struct {
    logic       rdy;
    logic       redir;
    logic [7:0] raddr;
    logic       req;
    logic [7:0] addr;
    logic       vld;
    logic [7:0] pc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic rdy, input logic rd, input logic [7:0] ra,
    input logic rq, input logic [7:0] a,
    input logic v, input logic [7:0] p
  );
    vec_t r;
    r.rdy = rdy; r.redir = rd; r.raddr = ra;
    r.req = rq; r.addr = a; r.vld = v; r.pc = p;
    return r;
  endfunction

  task automatic chk(
    input string nm, input logic [31:0] act, input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    // Cycle 0 enables; first word valid in cycle 3.
    tbl.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0, 8'h00));
    tbl.push_back(mk(1, 0, 8'h00, 1, 8'h00, 0, 8'h00));
    tbl.push_back(mk(1, 0, 8'h00, 1, 8'h01, 0, 8'h00));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(1, 0, 8'h00, 1, 8'(i + 2), 1, 8'(i)));
    // Five stall cycles: head held, requests stop.
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 8'h0A));
    tbl.push_back(mk(1, 0, 8'h00, 1, 8'h0C, 1, 8'h0A));
    tbl.push_back(mk(1, 0, 8'h00, 1, 8'h0D, 1, 8'h0B));
    tbl.push_back(mk(1, 0, 8'h00, 1, 8'h0E, 1, 8'h0C));
    tbl.push_back(mk(1, 0, 8'h00, 1, 8'h0F, 1, 8'h0D));
    // Redirect to 0x40 with request in flight.
    tbl.push_back(mk(1, 1, 8'h40, 1, 8'h10, 1, 8'h0E));
    tbl.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0, 8'h00));
    tbl.push_back(mk(1, 0, 8'h00, 1, 8'h40, 0, 8'h00));
    tbl.push_back(mk(1, 0, 8'h00, 1, 8'h41, 0, 8'h00));
    tbl.push_back(mk(1, 0, 8'h00, 1, 8'h42, 1, 8'h40));
    tbl.push_back(mk(1, 0, 8'h00, 1, 8'h43, 1, 8'h41));
    // Fill the queue ahead of the async reset.
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 8'h42));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 8'h42));

    #1 rst = 1'b1;
    #1;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_addr", 32'(addr), 32'h00);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_instr", 32'(instr), 32'h0);
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_addr_fe", 32'(addr_fe), 32'hFE);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      en = 1'b1;
      ready = tbl[i].rdy;
      redir = tbl[i].redir;
      raddr = tbl[i].raddr;
      #1;
      chk($sformatf("req[%0d]", i), 32'(req), 32'(tbl[i].req));
      if (tbl[i].req)
        chk($sformatf("addr[%0d]", i), 32'(addr), 32'(tbl[i].addr));
      chk($sformatf("valid[%0d]", i), 32'(valid), 32'(tbl[i].vld));
      if (tbl[i].vld) begin
        chk($sformatf("pc[%0d]", i), 32'(pc), 32'(tbl[i].pc));
        chk($sformatf("instr[%0d]", i), 32'(instr),
            32'(16'hA000 + {8'h00, tbl[i].pc}));
      end
    end

    // Async reset mid-cycle with a full queue.
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_req", 32'(req), 32'd0);
    chk("arst_addr", 32'(addr), 32'h00);
    chk("arst_pc", 32'(pc), 32'h00);
    chk("arst_instr", 32'(instr), 32'h0);

    @(negedge clk);
    rst = 1'b0;
    en = 1'b1;
    ready = 1'b1;
    en_fe = 1'b1;
    redir = 1'b0;

    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      ready = !(c >= 5 && c <= 7);
      redir = (c == 9 || c == 10);
      raddr = (c == 9) ? 8'h40 : 8'h80;
      #1;
      case (c)
        1: begin
          chk("re_req", 32'(req), 32'd1);
          chk("re_addr", 32'(addr), 32'h00);
        end
        3: begin
          chk("re_pc0", 32'(pc), 32'h00);
          chk("re_ins0", 32'(instr), 32'hA000);
          chk("fe_pc0", 32'(pc_fe), 32'hFE);
          chk("fe_ins0", 32'(instr_fe), 32'hA0FE);
        end
        4: begin
          chk("re_pc1", 32'(pc), 32'h01);
          chk("fe_pc1", 32'(pc_fe), 32'hFF);
          chk("fe_ins1", 32'(instr_fe), 32'hA0FF);
        end
        5: begin
          chk("fe_pc2", 32'(pc_fe), 32'h00);
          chk("fe_ins2", 32'(instr_fe), 32'hA000);
        end
        6: begin
          chk("fe_pc3", 32'(pc_fe), 32'h01);
          chk("fe_ins3", 32'(instr_fe), 32'hA001);
        end
        8: chk("hold_pc", 32'(pc), 32'h02);
        9: chk("pre_rd_pc", 32'(pc), 32'h03);
        10, 11: begin
          chk($sformatf("fl_valid%0d", c), 32'(valid), 32'd0);
          chk($sformatf("fl_req%0d", c), 32'(req), 32'd0);
        end
        12: begin
          chk("rd2_valid", 32'(valid), 32'd0);
          chk("rd2_req", 32'(req), 32'd1);
          chk("rd2_addr", 32'(addr), 32'h80);
        end
        13: chk("rd2_valid13", 32'(valid), 32'd0);
        14: begin
          chk("rd2_v", 32'(valid), 32'd1);
          chk("rd2_pc", 32'(pc), 32'h80);
          chk("rd2_ins", 32'(instr), 32'hA080);
        end
        default: ;
      endcase
      if (c >= 3 && c <= 9)
        chk($sformatf("re_valid%0d", c), 32'(valid), 32'd1);
    end

`ifdef FETCH_PERF_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'd3);
    chk("flush_cnt", 32'(flush_cnt), 32'd2);
    chk("stall_fe", 32'(stall_fe), 32'd0);
    chk("flush_fe", 32'(flush_fe), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
